// File: rtl/uart_alu_pkt_ctrl.sv
// uart_alu_pkt_ctrl: packet controller between the UART byte stream and a
// multi-cycle 32-bit ALU.
// Packet: opcode, reserved, len_lo, len_hi, then len payload bytes.
// Echo packets are returned byte by byte. Arithmetic packets fold their
// little-endian 32-bit words through the ALU, and the 4-byte result is sent back.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   rx_data_i/rx_valid_i                received byte strobe
//   tx_data_o/tx_valid_o/tx_ready_i     transmit handshake
//   alu_op_o/alu_a_o/alu_b_o            ALU command and operands
//   alu_start_o/alu_done_i/alu_result_i ALU start/done handshake
//   busy_o                              packet in progress
//   err_o                               one-cycle protocol error pulse
module uart_alu_pkt_ctrl #(
    parameter logic [7:0] OP_ECHO = 8'hEC,
    parameter logic [7:0] OP_ADD  = 8'h10,
    parameter logic [7:0] OP_MUL  = 8'h11,
    parameter logic [7:0] OP_DIV  = 8'h12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_start_o,
    input  logic        alu_done_i,
    input  logic [31:0] alu_result_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_DRAIN, S_RESP
    } state_t;

    typedef enum logic [1:0] {M_DISCARD, M_ECHO, M_ARITH} mode_t;

    state_t              r_state, w_state_n;
    mode_t               r_mode, w_mode_n;
    logic [7:0]          r_opcode, w_opcode_n;
    logic [7:0]          r_len_lo, w_len_lo_n;
    logic [CNT_W-1:0]    r_cnt, w_cnt_n;
    logic [1:0]          r_byte_idx, w_byte_idx_n;
    logic [23:0]         r_word, w_word_n;
    logic [WORD_W-1:0]   r_acc, w_acc_n;
    logic                r_acc_vld, w_acc_vld_n;
    // The pending word is the one in flight; alu_b_o holds it until done.
    logic                r_pend_full, w_pend_full_n;
    logic [1:0]          r_resp_idx, w_resp_idx_n;
    logic [7:0]          r_tx_data, w_tx_data_n;
    logic                r_tx_valid, w_tx_valid_n;
    logic [1:0]          r_alu_op, w_alu_op_n;
    logic [WORD_W-1:0]   r_alu_a, w_alu_a_n;
    logic [WORD_W-1:0]   r_alu_b, w_alu_b_n;
    logic                r_alu_start, w_alu_start_n;
    logic                r_busy, w_busy_n;
    logic                r_err, w_err_n;

    logic [CNT_W-1:0]    w_len;
    logic [WORD_W-1:0]   w_word_full;
    logic                w_is_arith;
    logic [1:0]          w_op_sel;
    logic [1:0]          w_resp_nxt;
    logic [7:0]          w_resp_byte;

    assign w_len       = {rx_data_i, r_len_lo};
    assign w_word_full = {rx_data_i, r_word};
    assign w_is_arith  = (r_opcode == OP_ADD) || (r_opcode == OP_MUL) || (r_opcode == OP_DIV);
    assign w_op_sel    = (r_opcode == OP_MUL) ? 2'd1 : (r_opcode == OP_DIV) ? 2'd2 : 2'd0;
    assign w_resp_nxt  = 2'(r_resp_idx + 2'd1);
    assign w_resp_byte = r_acc[{w_resp_nxt, 3'b000} +: 8];

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_mode      <= M_DISCARD;
            r_opcode    <= '0;
            r_len_lo    <= '0;
            r_cnt       <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_acc       <= '0;
            r_acc_vld   <= 1'b0;
            r_pend_full <= 1'b0;
            r_resp_idx  <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_mode      <= w_mode_n;
            r_opcode    <= w_opcode_n;
            r_len_lo    <= w_len_lo_n;
            r_cnt       <= w_cnt_n;
            r_byte_idx  <= w_byte_idx_n;
            r_word      <= w_word_n;
            r_acc       <= w_acc_n;
            r_acc_vld   <= w_acc_vld_n;
            r_pend_full <= w_pend_full_n;
            r_resp_idx  <= w_resp_idx_n;
            r_tx_data   <= w_tx_data_n;
            r_tx_valid  <= w_tx_valid_n;
            r_alu_op    <= w_alu_op_n;
            r_alu_a     <= w_alu_a_n;
            r_alu_b     <= w_alu_b_n;
            r_alu_start <= w_alu_start_n;
            r_busy      <= w_busy_n;
            r_err       <= w_err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_n     = r_state;
        w_mode_n      = r_mode;
        w_opcode_n    = r_opcode;
        w_len_lo_n    = r_len_lo;
        w_cnt_n       = r_cnt;
        w_byte_idx_n  = r_byte_idx;
        w_word_n      = r_word;
        w_acc_n       = r_acc;
        w_acc_vld_n   = r_acc_vld;
        w_pend_full_n = r_pend_full;
        w_resp_idx_n  = r_resp_idx;
        w_tx_data_n   = r_tx_data;
        w_tx_valid_n  = r_tx_valid;
        w_alu_op_n    = r_alu_op;
        w_alu_a_n     = r_alu_a;
        w_alu_b_n     = r_alu_b;
        w_alu_start_n = 1'b0;
        w_err_n       = 1'b0;

        // A done only counts while an op is outstanding, so stale dones after reset are ignored.
        // It frees pending before any word completing in the same cycle is considered.
        if (alu_done_i && r_pend_full) begin
            w_acc_n       = alu_result_i;
            w_pend_full_n = 1'b0;
        end

        if (r_tx_valid && tx_ready_i) begin
            w_tx_valid_n = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (rx_valid_i) begin
                    w_opcode_n = rx_data_i;
                    w_state_n  = S_RSV;
                end
            end
            S_RSV: begin
                if (rx_valid_i) begin
                    w_state_n = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid_i) begin
                    w_len_lo_n = rx_data_i;
                    w_state_n  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid_i) begin
                    w_cnt_n      = w_len;
                    w_byte_idx_n = '0;
                    w_acc_n      = '0;
                    w_acc_vld_n  = 1'b0;
                    if (w_len == '0) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_PAYLOAD;
                        if (r_opcode == OP_ECHO) begin
                            w_mode_n = M_ECHO;
                        end else if (w_is_arith && (w_len[1:0] == 2'd0)) begin
                            w_mode_n = M_ARITH;
                        end else begin
                            w_mode_n = M_DISCARD;
                            w_err_n  = w_is_arith;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (r_cnt == '0) begin
                    // Only echo sits here: all bytes taken, waiting for the hold register to drain.
                    w_err_n = rx_valid_i;
                    if (!w_tx_valid_n) begin
                        w_state_n = S_IDLE;
                    end
                end else if (rx_valid_i) begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                    case (r_mode)
                        M_ECHO: begin
                            if (r_tx_valid && !tx_ready_i) begin
                                w_err_n = 1'b1;
                            end else begin
                                w_tx_data_n  = rx_data_i;
                                w_tx_valid_n = 1'b1;
                            end
                        end
                        M_ARITH: begin
                            w_word_n     = w_word_full[31:8];
                            w_byte_idx_n = 2'(r_byte_idx + 2'd1);
                            if (r_byte_idx == 2'd3) begin
                                if (!r_acc_vld) begin
                                    w_acc_n     = w_word_full;
                                    w_acc_vld_n = 1'b1;
                                end else if (!w_pend_full_n) begin
                                    w_pend_full_n = 1'b1;
                                    w_alu_start_n = 1'b1;
                                    w_alu_op_n    = w_op_sel;
                                    w_alu_a_n     = w_acc_n;
                                    w_alu_b_n     = w_word_full;
                                end else begin
                                    w_err_n = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_mode == M_ARITH) begin
                            w_state_n = S_DRAIN;
                        end else if (r_mode == M_DISCARD) begin
                            w_state_n = S_IDLE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                w_err_n = rx_valid_i;
                if (!r_pend_full) begin
                    w_state_n    = S_RESP;
                    w_resp_idx_n = '0;
                    w_tx_data_n  = r_acc[7:0];
                    w_tx_valid_n = 1'b1;
                end
            end
            S_RESP: begin
                w_err_n = rx_valid_i;
                if (r_tx_valid && tx_ready_i) begin
                    if (r_resp_idx == 2'd3) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_resp_idx_n = w_resp_nxt;
                        w_tx_data_n  = w_resp_byte;
                        w_tx_valid_n = 1'b1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        w_busy_n = (w_state_n != S_IDLE);
    end

    assign tx_data_o   = r_tx_data;
    assign tx_valid_o  = r_tx_valid;
    assign alu_op_o    = r_alu_op;
    assign alu_a_o     = r_alu_a;
    assign alu_b_o     = r_alu_b;
    assign alu_start_o = r_alu_start;
    assign busy_o      = r_busy;
    assign err_o       = r_err;

endmodule

// File: tb/tb_uart_alu_pkt_ctrl.sv
// Directed bench for uart_alu_pkt_ctrl: echo, add, mul chain, bad length,
// pending overflow and mid-packet reset, with a behavioural ALU and TX sink.
module tb_uart_alu_pkt_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_start_o;
    logic        alu_done_i;
    logic [31:0] alu_result_i;
    logic        busy_o;
    logic        err_o;

    int n_pass  = 0;
    int n_total = 0;
    int err_cnt = 0;
    int stall   = 0;
    int alu_lat = 3;

    logic [7:0]  tx_q[$];
    logic [31:0] st_a[$];
    logic [31:0] st_b[$];
    logic [1:0]  st_op[$];

    always #5 clk_i = ~clk_i;

    uart_alu_pkt_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .alu_op_o     (alu_op_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_start_o  (alu_start_o),
        .alu_done_i   (alu_done_i),
        .alu_result_i (alu_result_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // Monitors sample mid-cycle
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
            if (err_o) err_cnt++;
            if (alu_start_o) begin
                st_a.push_back(alu_a_o);
                st_b.push_back(alu_b_o);
                st_op.push_back(alu_op_o);
            end
        end
    end

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return p[31:0];
            default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    // Behavioural ALU: done alu_lat cycles after start
    initial begin
        logic [31:0] ma, mb;
        logic [1:0]  mop;
        alu_done_i   = 1'b0;
        alu_result_i = 32'd0;
        forever begin
            @(negedge clk_i);
            if (alu_start_o) begin
                ma  = alu_a_o;
                mb  = alu_b_o;
                mop = alu_op_o;
                repeat (alu_lat) @(posedge clk_i);
                #1;
                alu_result_i = alu_f(mop, ma, mb);
                alu_done_i   = 1'b1;
                @(posedge clk_i);
                #1;
                alu_done_i   = 1'b0;
            end
        end
    end

    // TX sink: holds ready low for `stall` cycles per byte
    initial begin
        int wcnt;
        wcnt       = 0;
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall == 0) begin
                tx_ready_i = 1'b1;
            end else if (tx_valid_o && !tx_ready_i) begin
                wcnt++;
                if (wcnt >= stall) begin
                    tx_ready_i = 1'b1;
                    wcnt       = 0;
                end
            end else begin
                tx_ready_i = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int c;
        c = 0;
        while (tx_q.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy_o !== 1'b0 && c < budget) begin
            tick();
            c++;
        end
    endtask

    function automatic logic [7:0] gb(input int i);
        if (i < tx_q.size()) return tx_q[i];
        return 8'hxx;
    endfunction

    function automatic logic [31:0] gw(input int base);
        return {gb(base + 3), gb(base + 2), gb(base + 1), gb(base)};
    endfunction

    initial begin
        int e0, t0, s0;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) tick();
        chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_tx_data",  32'(tx_data_o),  32'd0);
        chk("rst_start",    32'(alu_start_o), 32'd0);
        chk("rst_a",        alu_a_o, 32'd0);
        chk("rst_b",        alu_b_o, 32'd0);
        chk("rst_op",       32'(alu_op_o), 32'd0);
        chk("rst_busy",     32'(busy_o), 32'd0);
        chk("rst_err",      32'(err_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Echo with stalled transmitter
        stall = 5; e0 = err_cnt; t0 = tx_q.size();
        send(8'hEC, 0); send(8'h00, 0); send(8'h03, 0); send(8'h00, 0);
        rx_data_i  = 8'hA1;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        chk("echo_lat_valid", 32'(tx_valid_o), 32'd1);
        chk("echo_lat_data",  32'(tx_data_o), 32'hA1);
        chk("echo_busy",      32'(busy_o), 32'd1);
        repeat (10) tick();
        send(8'hB2, 10); send(8'hC3, 10);
        wait_tx(t0 + 3, 500);
        wait_idle(500);
        chk("echo_count", 32'(tx_q.size() - t0), 32'd3);
        chk("echo_b0", 32'(gb(t0)), 32'hA1);
        chk("echo_b1", 32'(gb(t0 + 1)), 32'hB2);
        chk("echo_b2", 32'(gb(t0 + 2)), 32'hC3);
        chk("echo_err", 32'(err_cnt - e0), 32'd0);
        chk("echo_idle", 32'(busy_o), 32'd0);

        // Add with wrap
        stall = 0; alu_lat = 3; e0 = err_cnt; t0 = tx_q.size(); s0 = st_a.size();
        send(8'h10, 0); send(8'h00, 0); send(8'h08, 0); send(8'h00, 0);
        send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0);
        send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        wait_tx(t0 + 4, 500);
        wait_idle(500);
        chk("add_count", 32'(tx_q.size() - t0), 32'd4);
        chk("add_result", gw(t0), 32'h0000_0001);
        chk("add_starts", 32'(st_a.size() - s0), 32'd1);
        chk("add_a", st_a[s0], 32'hFFFF_FFFF);
        chk("add_b", st_b[s0], 32'h0000_0002);
        chk("add_op", 32'(st_op[s0]), 32'd0);
        chk("add_err", 32'(err_cnt - e0), 32'd0);

        // Mul chain, slow ALU, UART-paced bytes
        alu_lat = 40; e0 = err_cnt; t0 = tx_q.size(); s0 = st_a.size();
        send(8'h11, 0); send(8'h00, 0); send(8'h0C, 0); send(8'h00, 0);
        send(8'h03, 16); send(8'h00, 16); send(8'h00, 16); send(8'h00, 16);
        send(8'h04, 16); send(8'h00, 16); send(8'h00, 16); send(8'h00, 16);
        send(8'h05, 16); send(8'h00, 16); send(8'h00, 16); send(8'h00, 16);
        wait_tx(t0 + 4, 1000);
        wait_idle(500);
        chk("mul_result", gw(t0), 32'h0000_003C);
        chk("mul_starts", 32'(st_a.size() - s0), 32'd2);
        chk("mul_a1", st_a[s0 + 1], 32'h0000_000C);
        chk("mul_b1", st_b[s0 + 1], 32'h0000_0005);
        chk("mul_op", 32'(st_op[s0 + 1]), 32'd1);
        chk("mul_err", 32'(err_cnt - e0), 32'd0);

        // Bad length, unknown opcode, then len 4 add
        alu_lat = 3; e0 = err_cnt; t0 = tx_q.size(); s0 = st_a.size();
        send(8'h10, 0); send(8'h00, 0); send(8'h06, 0); send(8'h00, 0);
        for (int i = 0; i < 6; i++) send(8'(8'h11 + i), 0);
        send(8'h55, 0); send(8'h00, 0); send(8'h02, 0); send(8'h00, 0);
        send(8'hAA, 0); send(8'hBB, 0);
        send(8'h10, 0); send(8'h00, 0); send(8'h04, 0); send(8'h00, 0);
        send(8'h2A, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        chk("len4_early", 32'(tx_valid_o), 32'd0);
        tick();
        chk("len4_valid", 32'(tx_valid_o), 32'd1);
        chk("len4_data",  32'(tx_data_o), 32'h2A);
        wait_tx(t0 + 4, 500);
        wait_idle(500);
        chk("bad_count", 32'(tx_q.size() - t0), 32'd4);
        chk("bad_result", gw(t0), 32'h0000_002A);
        chk("bad_err", 32'(err_cnt - e0), 32'd1);
        chk("bad_starts", 32'(st_a.size() - s0), 32'd0);

        // Pending overflow on divide
        alu_lat = 150; e0 = err_cnt; t0 = tx_q.size(); s0 = st_a.size();
        send(8'h12, 0); send(8'h00, 0); send(8'h0C, 0); send(8'h00, 0);
        send(8'h64, 16); send(8'h00, 16); send(8'h00, 16); send(8'h00, 16);
        send(8'h07, 16); send(8'h00, 16); send(8'h00, 16); send(8'h00, 16);
        send(8'h09, 16); send(8'h00, 16); send(8'h00, 16); send(8'h00, 16);
        wait_tx(t0 + 4, 1000);
        wait_idle(500);
        repeat (5) tick();
        chk("ovf_err", 32'(err_cnt - e0), 32'd1);
        chk("ovf_count", 32'(tx_q.size() - t0), 32'd4);
        chk("ovf_result", gw(t0), 32'h0000_000E);
        chk("ovf_starts", 32'(st_a.size() - s0), 32'd1);
        chk("ovf_op", 32'(st_op[s0]), 32'd2);

        // Reset mid-packet, then a fresh echo
        alu_lat = 3; e0 = err_cnt; s0 = st_a.size();
        send(8'h10, 0); send(8'h00, 0); send(8'h08, 0); send(8'h00, 0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_txv", 32'(tx_valid_o), 32'd0);
        t0 = tx_q.size();
        send(8'hEC, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0);
        send(8'h7E, 0);
        wait_tx(t0 + 1, 500);
        wait_idle(500);
        repeat (10) tick();
        chk("rst_echo_count", 32'(tx_q.size() - t0), 32'd1);
        chk("rst_echo_byte", 32'(gb(t0)), 32'h7E);
        chk("rst_starts", 32'(st_a.size() - s0), 32'd0);
        chk("rst_err", 32'(err_cnt - e0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_alu_pkt_ctrl.md
# uart_alu_pkt_ctrl

Packet-level controller between the UART receiver/transmitter and the arithmetic datapath inside `uart_alu`. It parses the framed byte stream (opcode, reserved, 16-bit little-endian length, payload), echoes payload bytes for the echo opcode, and sequences a multi-cycle ALU through a start/done handshake to fold 32-bit operands for arithmetic opcodes. It then streams the 32-bit result back to the transmitter.

## Interface
- `OP_ECHO`, default 8'hEC: echo opcode.
- `OP_ADD`, default 8'h10: 32-bit add, wrap-around.
- `OP_MUL`, default 8'h11: 32-bit multiply, low 32 bits kept.
- `OP_DIV`, default 8'h12: 32-bit unsigned divide; the ALU defines divide-by-zero behaviour.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `rx_data_i` in 8: received byte.
- `rx_valid_i` in 1: one-cycle strobe, `rx_data_i` valid.
- `tx_data_o` out 8: byte to transmitter.
- `tx_valid_o` out 1: `tx_data_o` valid.
- `tx_ready_i` in 1: transmitter accepts the byte when `tx_valid_o & tx_ready_i`.
- `alu_op_o` out 2: 0 add, 1 mul, 2 div.
- `alu_a_o`, `alu_b_o` out 32: operands, held stable from start until done.
- `alu_start_o` out 1: one-cycle start pulse.
- `alu_done_i` in 1: one-cycle pulse, at least 1 cycle after start.
- `alu_result_i` in 32: valid in the cycle `alu_done_i` is high.
- `busy_o` out 1: high in any state other than IDLE.
- `err_o` out 1: one-cycle pulse on a protocol error.

## Operation
**States:** IDLE → RSV → LEN_LO → LEN_HI → PAYLOAD → DRAIN → RESP → IDLE.
- Each header state advances on one `rx_valid_i`.
- `len = {LEN_HI, LEN_LO}` counts payload bytes only.

**Length handling**
- LEN_HI with `len == 0` → IDLE.
- Arithmetic opcode with `len % 4 != 0` → PAYLOAD in discard mode. `err_o` pulses on LEN_HI acceptance.

**PAYLOAD** (16-bit down counter, exits when it reaches 0)
- Echo: each byte is loaded into a 1-byte hold register, which drives `tx_valid_o`. A byte arriving while the hold register is still full is dropped and `err_o` pulses.
- Unknown opcode or discard mode: bytes are counted and dropped; no response. Exit → IDLE.
- Arithmetic: bytes are assembled little-endian into a 32-bit word.
  - First word loads the accumulator directly.
  - Each later word goes to a pending register. When the ALU is idle, the controller issues `alu_a_o=acc`, `alu_b_o=pending`, `alu_start_o`.
  - On `alu_done_i`: `acc <= alu_result_i` and the pending register is freed.
  - If a word completes while pending is still occupied, the word is dropped, `err_o` pulses, and the response is still sent.
  - Exit → DRAIN.

**DRAIN**
- Wait until pending is empty and the ALU is idle, then → RESP.

**RESP**
- Send acc[7:0], [15:8], [23:16], [31:24], one byte per valid/ready handshake. After the 4th byte → IDLE.
- `rx_valid_i` during DRAIN or RESP: byte dropped, `err_o` pulses.

**Echo exit**
- After the last byte is accepted and the hold register has drained → IDLE.

**Reset**
- Reset mid-packet aborts immediately. Counter, accumulator, pending and hold registers clear.
- An ALU operation still in flight is ignored: `alu_done_i` is ignored in IDLE.

## Timing
**Reset values:** `tx_valid_o=0`, `tx_data_o=0`, `alu_start_o=0`, `alu_a_o=0`, `alu_b_o=0`, `alu_op_o=0`, `busy_o=0`, `err_o=0`.

**Latencies**
- Echo: `tx_valid_o` rises the cycle after `rx_valid_i`.
- `alu_start_o` fires the cycle after the operand's 4th byte strobe when the ALU is idle. Otherwise it fires the cycle after `alu_done_i`.
- RESP byte 0 `tx_valid_o` rises 1 cycle after DRAIN exit. For `len == 4` there is no ALU op, and the response starts 2 cycles after the last `rx_valid_i`.

**Handshake rules**
- `tx_valid_o` is registered and has no combinational path from `tx_ready_i`.
- Once `tx_valid_o` is high, `tx_data_o` holds until accepted.
- Back-to-back bytes are allowed on consecutive ready cycles.
- ALU ops are strictly serial: at most one outstanding.

**Simultaneous events**
- `alu_done_i` and a completing word in the same cycle: the done frees pending first, so the new word is accepted with no error.

## Test plan
- **Echo:** EC 00 03 00 A1 B2 C3, `tx_ready_i` stalled 5 cycles per byte → TX emits A1 B2 C3 in order; `err_o` never pulses.
- **Add with wrap:** 10 00 08 00 FF FF FF FF 02 00 00 00 → TX emits 01 00 00 00; exactly one `alu_start_o` with a=FFFFFFFF, b=00000002.
- **Mul chain:** 11 00 0C 00 03 00 00 00 04 00 00 00 05 00 00 00, ALU done latency 40 cycles → TX emits 3C 00 00 00; two starts, second with a=0000000C.
- **Bad length / unknown opcode:** 10 00 06 00 + 6 bytes, then 55 00 02 00 + 2 bytes, then 10 00 04 00 2A 00 00 00 → one `err_o` pulse; only response is 2A 00 00 00.
- **Pending overflow:** div, len 12, ALU done latency longer than two operand times → `err_o` pulses once; the response is still 4 bytes.
- **Reset mid-packet:** `rst_i` high 1 cycle after LEN_HI of an add packet, then a fresh echo packet EC 00 01 00 7E → `busy_o=0` after reset; TX emits only 7E.
